// File: rtl/dmem_arb_if.sv
// Two-master data-memory port bundle: master request/grant/read-return lanes plus the shared memory side.
// The slave modport is the arbiter; the master modport is the masters-plus-memory environment.
interface dmem_arb_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_we;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_we;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  drdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output daddr, dwdata, dwe
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output drdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  daddr, dwdata, dwe
  );
endinterface

// File: rtl/dmem_arb.sv
// Two-master arbiter for a single-port synchronous-read data memory; grant is combinational, read data returns 1 cycle after grant.
// Owner keeps the port for up to MAX_BURST grants while the other master waits; a waiting master simply stays ungranted.
module dmem_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic    clk,
  input  logic    reset,
  dmem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

  localparam logic [3:0] MaxB = 4'(MAX_BURST);

  owner_e     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;
  logic       rpend_q, rpend_d;
  logic       rsel_q, rsel_d;

  logic gnt0, gnt1, keep;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    keep = 1'b0;
    case (owner_q)
      OWN0: begin
        keep = bus.m0_req && (!bus.m1_req || (cnt_q < MaxB));
        gnt0 = keep;
        gnt1 = !keep && bus.m1_req;
      end
      OWN1: begin
        keep = bus.m1_req && (!bus.m0_req || (cnt_q < MaxB));
        gnt1 = keep;
        gnt0 = !keep && bus.m0_req;
      end
      default: begin
        gnt0 = bus.m0_req && (!bus.m1_req || !rr_q);
        gnt1 = bus.m1_req && (!bus.m0_req || rr_q);
      end
    endcase
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    if (gnt0) begin
      if (owner_q == OWN0) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        owner_d = OWN0;
        cnt_d   = 4'd1;
        rr_d    = 1'b1;
      end
    end else if (gnt1) begin
      if (owner_q == OWN1) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        owner_d = OWN1;
        cnt_d   = 4'd1;
        rr_d    = 1'b0;
      end
    end else begin
      owner_d = IDLE;
      cnt_d   = 4'd0;
    end
    rpend_d = (gnt0 && (bus.m0_we == 4'd0)) || (gnt1 && (bus.m1_we == 4'd0));
    rsel_d  = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : rsel_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= IDLE;
      cnt_q   <= 4'd0;
      rr_q    <= 1'b0;
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;
  assign bus.daddr  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : 32'd0);
  assign bus.dwdata = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : 32'd0);
  assign bus.dwe    = gnt0 ? bus.m0_we    : (gnt1 ? bus.m1_we    : 4'd0);

  // A reset landing on the return cycle kills the pending read.
  assign bus.m0_rvalid = rpend_q && !rsel_q && !reset;
  assign bus.m1_rvalid = rpend_q &&  rsel_q && !reset;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.drdata : 32'd0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.drdata : 32'd0;

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed scenarios plus random traffic, every cycle compared to a rule-level arbitration model.
// A second instance with MAX_BURST=1 sees constant contention to show strict alternation.
module tb_dmem_arb;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arb_if bus ();
  dmem_arb_if bus1 ();

  dmem_arb #(.MAX_BURST(MAXB)) dut  (.clk(clk), .reset(reset), .bus(bus));
  dmem_arb #(.MAX_BURST(1))    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int compared = 0;
  int mismatched = 0;

  // Reference model: owner -1 means nobody holds the port.
  int m_own = -1, m_cnt = 0, m_rr = 0, m_rsel = 0;
  bit m_rpend = 1'b0;
  int g = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(bit r0, bit r1);
    bit r [2];
    r[0] = r0;
    r[1] = r1;
    if (reset) return -1;
    if (m_own >= 0) begin
      if (r[m_own] && (!r[1 - m_own] || m_cnt < MAXB)) return m_own;
      if (r[1 - m_own]) return 1 - m_own;
      return -1;
    end
    if (r0 && r1) return m_rr;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Let inputs settle, then compare every DUT output to the model.
  task automatic settle();
    logic [31:0] ea, ew;
    logic [3:0]  ewe;
    bit v0, v1;
    #2;
    g = pick(bus.m0_req, bus.m1_req);
    ea  = (g == 0) ? bus.m0_addr  : (g == 1) ? bus.m1_addr  : 32'd0;
    ew  = (g == 0) ? bus.m0_wdata : (g == 1) ? bus.m1_wdata : 32'd0;
    ewe = (g == 0) ? bus.m0_we    : (g == 1) ? bus.m1_we    : 4'd0;
    v0 = m_rpend && !reset && (m_rsel == 0);
    v1 = m_rpend && !reset && (m_rsel == 1);
    chk("m0_gnt", 32'(bus.m0_gnt), 32'(g == 0));
    chk("m1_gnt", 32'(bus.m1_gnt), 32'(g == 1));
    chk("daddr", bus.daddr, ea);
    chk("dwdata", bus.dwdata, ew);
    chk("dwe", 32'(bus.dwe), 32'(ewe));
    chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(v0));
    chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(v1));
    chk("m0_rdata", bus.m0_rdata, v0 ? bus.drdata : 32'd0);
    chk("m1_rdata", bus.m1_rdata, v1 ? bus.drdata : 32'd0);
  endtask

  task automatic advance();
    logic [3:0] gwe;
    gwe = (g == 0) ? bus.m0_we : bus.m1_we;
    @(posedge clk);
    if (reset) begin
      m_own = -1; m_cnt = 0; m_rr = 0; m_rpend = 1'b0;
    end else begin
      if (g < 0) begin
        m_own = -1; m_cnt = 0;
      end else if (g == m_own) begin
        m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
      end else begin
        m_own = g; m_cnt = 1; m_rr = 1 - g;
      end
      m_rpend = (g >= 0) && (gwe == 4'd0);
      if (g >= 0) m_rsel = g;
    end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic drive(input bit r0, input bit r1, input logic [3:0] we0, input logic [3:0] we1);
    bus.m0_req = r0; bus.m1_req = r1;
    bus.m0_we = we0; bus.m1_we = we1;
    bus.m0_addr = $urandom; bus.m1_addr = $urandom;
    bus.m0_wdata = $urandom; bus.m1_wdata = $urandom;
    bus.drdata = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    bus1.m0_req = 1'b1; bus1.m1_req = 1'b1;
    bus1.m0_we = 4'd0; bus1.m1_we = 4'd0;
    bus1.m0_addr = 32'h100; bus1.m1_addr = 32'h200;
    bus1.m0_wdata = 32'd0; bus1.m1_wdata = 32'd0;
    bus1.drdata = 32'd0;

    // Reset holds every output low even with requests present.
    drive(1, 1, 4'd0, 4'hF);
    tick();
    drive(1, 1, 4'd3, 4'd0);
    tick();

    // Continuous contention: bursts of four, alternation on the MAX_BURST=1 copy.
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 4'd0, 4'd0);
      settle();
      chk("burst_m0", 32'(bus.m0_gnt), 32'(i < 4 || i >= 8));
      chk("burst_m1", 32'(bus.m1_gnt), 32'(i >= 4 && i < 8));
      chk("alt_m0", 32'(bus1.m0_gnt), 32'((i % 2) == 0));
      chk("alt_m1", 32'(bus1.m1_gnt), 32'((i % 2) == 1));
      advance();
    end
    drive(0, 0, 4'd0, 4'd0);
    settle();
    chk("burst_last_rvalid", 32'(bus.m0_rvalid), 32'd1);
    advance();

    // Lone write: passes straight through, no read return.
    drive(1, 0, 4'b0100, 4'd0);
    bus.m0_addr = 32'h10; bus.m0_wdata = 32'hAAAAAAAA;
    settle();
    chk("wr_daddr", bus.daddr, 32'h10);
    chk("wr_dwe", 32'(bus.dwe), 32'h4);
    chk("wr_gnt", 32'(bus.m0_gnt), 32'd1);
    advance();
    drive(0, 0, 4'd0, 4'd0);
    settle();
    chk("wr_no_rvalid", 32'(bus.m0_rvalid), 32'd0);
    advance();

    // m1 read returns memory data next cycle.
    drive(0, 1, 4'd0, 4'd0);
    bus.m1_addr = 32'h20;
    settle();
    chk("rd_daddr", bus.daddr, 32'h20);
    advance();
    drive(0, 0, 4'd0, 4'd0);
    bus.drdata = 32'h12345678;
    settle();
    chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    chk("rd_m1_rdata", bus.m1_rdata, 32'h12345678);
    chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    advance();

    // m0 owns for two grants, then drops as m1 arrives: immediate switch.
    drive(1, 0, 4'd0, 4'd0); tick();
    drive(1, 0, 4'd0, 4'd0); tick();
    drive(0, 1, 4'd0, 4'd0);
    settle();
    chk("switch_m1", 32'(bus.m1_gnt), 32'd1);
    advance();
    drive(0, 0, 4'd0, 4'd0); tick();
    drive(1, 1, 4'd0, 4'd0);
    settle();
    chk("rr_after_switch", 32'(bus.m0_gnt), 32'd1);
    advance();

    // Reset on the return cycle of a read.
    drive(0, 1, 4'd0, 4'd0); tick();
    drive(0, 0, 4'd0, 4'd0);
    reset = 1'b1;
    settle();
    chk("rst_kill_rvalid", 32'(bus.m1_rvalid), 32'd0);
    advance();
    reset = 1'b0;
    drive(1, 1, 4'd0, 4'd0);
    settle();
    chk("rst_then_m0", 32'(bus.m0_gnt), 32'd1);
    advance();

    // m1 tenure, three idle cycles, then contention goes to m0.
    drive(0, 1, 4'd0, 4'd0); tick();
    drive(0, 1, 4'hF, 4'd0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'hF, 4'hF);
      settle();
      chk("idle_dwe", 32'(bus.dwe), 32'd0);
      advance();
    end
    drive(1, 1, 4'd0, 4'd0);
    settle();
    chk("idle_rr_m0", 32'(bus.m0_gnt), 32'd1);
    advance();

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom));
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, the maximum consecutive grants to one master while the other master is waiting (legal range 1..15).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port m0_req  input  1  master 0 access request; held until granted.
REQ-005 SHALL have port m0_addr  input  32  master 0 byte address.
REQ-006 SHALL have port m0_wdata  input  32  master 0 write data, lane-replicated by the master.
REQ-007 SHALL have port m0_we  input  4  master 0 byte write enables; 0 = read.
REQ-008 SHALL have port m0_gnt  output  1  master 0 access accepted this cycle.
REQ-009 SHALL have port m0_rvalid  output  1  master 0 read data valid.
REQ-010 SHALL have port m0_rdata  output  32  master 0 read data.
REQ-011 SHALL have ports m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata, identical to the m0 ports, for master 1.
REQ-012 SHALL have port daddr  output  32  memory address.
REQ-013 SHALL have port dwdata  output  32  memory write data.
REQ-014 SHALL have port dwe  output  4  memory byte write enables.
REQ-015 SHALL have port drdata  input  32  memory read data, valid one cycle after the address (synchronous read).

Function
REQ-016 SHALL hold the following state: owner register {IDLE, OWN0, OWN1}, tenure counter cnt (4 bits), round-robin pointer rr (0/1), and registered read tag {rpend, rsel}.
REQ-017 SHALL compute the grant combinationally each cycle from the registered state and m0_req/m1_req, and SHALL never assert m0_gnt and m1_gnt together.
REQ-018 In IDLE, SHALL grant the sole requester; if both request, SHALL grant master rr.
REQ-019 In OWNx, SHALL regrant x if x requests and either the other master is idle or cnt < MAX_BURST.
REQ-020 In OWNx, if x is not regranted and the other master requests, SHALL grant the other master.
REQ-021 In OWNx, if no master requests, SHALL grant none.
REQ-022 On a grant to the current owner, cnt SHALL increment, saturating at 15.
REQ-023 On a grant to a new owner, cnt SHALL load 1, the owner SHALL be set to that master, and rr SHALL point to the other master.
REQ-024 On a cycle with no grant, the owner SHALL become IDLE and cnt SHALL clear to 0; rr SHALL be kept.
REQ-025 In the grant cycle, daddr, dwdata and dwe SHALL equal the granted master's addr, wdata and we.
REQ-026 With no grant, daddr, dwdata and dwe SHALL all be 0.
REQ-027 A granted read (we == 0) SHALL set rpend=1 and rsel=master for the next cycle; any other cycle SHALL clear rpend.
REQ-028 mX_rvalid SHALL equal rpend && rsel == X, with latency exactly 1 cycle after gnt; mX_rdata SHALL equal drdata when valid, else 0.
REQ-029 Writes SHALL produce no rvalid; a write SHALL complete in its grant cycle.
REQ-030 Back-to-back grants SHALL be supported: a read in cycle N and any access in cycle N+1 both proceed, giving one access per cycle throughput.
REQ-031 A master dropping req in the same cycle it would be regranted SHALL NOT be granted; the arbiter SHALL switch or go IDLE per REQ-020/REQ-021.
REQ-032 MAX_BURST=1 SHALL degenerate to strict alternation under continuous contention.

Reset
REQ-033 While reset is high: owner=IDLE, cnt=0, rr=0 (master 0 favoured), rpend=0.
REQ-034 While reset is high: m0_gnt=m1_gnt=0, rvalid=0, rdata=0, daddr=dwdata=0, dwe=0, regardless of requests.
REQ-035 Reset asserted the cycle after a granted read SHALL suppress that read's rvalid.
REQ-036 The first cycle after reset SHALL arbitrate from IDLE.

Verification
REQ-037 Reset release, both masters reading continuously, MAX_BURST=4 -> m0 granted cycles 1-4, m1 cycles 5-8, m0 cycles 9-12; each rvalid one cycle after its gnt.
REQ-038 m0 write addr 0x10, we=4'b0100, wdata 0xAAAAAAAA; m1 idle -> same cycle: daddr=0x10, dwe=4'b0100, m0_gnt=1; no m0_rvalid next cycle.
REQ-039 m1 reads 0x20, memory returns 0x12345678 -> m1_rvalid=1 and m1_rdata=0x12345678 next cycle; m0_rvalid stays 0.
REQ-040 m0 owns with cnt=2, m1 starts requesting, m0 drops req -> m1 granted immediately with cnt=1; rr then points to m0.
REQ-041 Reset pulsed in the cycle after a granted read -> no rvalid; next cycle both request -> m0 granted.
REQ-042 No requests for 3 cycles after m1 tenure, then both request -> m0 granted (rr kept); dwe=0 throughout the idle cycles.
